dmem_resp: RTL
==============

// Module: dmem_resp
// PURPOSE
//  Data-memory responder: the memory end of the MEM-stage load/store interface (ce/we/addr/sel/data).
//  Holds a word-organised, byte-lane-writable RAM with configurable access latency.
//  Stalls the pipeline via stallreq_o until each access completes; returns full words.
//  Byte order is big-endian: sel[3]/data[31:24] is byte address 0, sel[0]/data[7:0] is byte address 3.
// PARAMETERS
//  ADDR_W       10  word-address bits; depth = 2**ADDR_W words (index = mem_addr_i[ADDR_W+1:2])
//  WAIT_CYCLES  1   extra wait states before access; legal range 0..15
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  mem_ce_i     in   1   request valid, held by requester while stallreq_o=1
//  mem_we_i     in   1   1=store, 0=load
//  mem_addr_i   in   32  byte address; bits [1:0] ignored, the sel lanes carry alignment
//  mem_sel_i    in   4   byte-lane enables for stores
//  mem_data_i   in   32  store data, already lane-replicated by requester
//  mem_data_o   out  32  load data, full word, registered
//  stallreq_o   out  1   1 = hold pipeline, access not yet complete
//  mem_err_o    out  1   only with DMEM_ERR_EN: out-of-range access flag
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, cnt=0, mem_data_o=0, mem_err_o=0; RAM contents not reset.
//  - FSM states IDLE, WAIT, DONE; 4-bit down-counter cnt.
//  - IDLE: mem_ce_i=1 -> latch we/addr/sel/data, cnt<=WAIT_CYCLES, go WAIT. Otherwise stay.
//  - WAIT: cnt!=0 -> cnt<=cnt-1; cnt==0 -> perform access at this edge, go DONE.
//    Access: store writes lanes with sel bit set (sel=0000 writes nothing); load captures word into mem_data_o.
//  - DONE: access complete; go IDLE next edge unconditionally.
//  - stallreq_o = mem_ce_i && (state != DONE), combinational.
//  - Latency: request seen in cycle 0 -> stallreq high cycles 0..WAIT_CYCLES+1, low in cycle WAIT_CYCLES+2.
//  - The latched request is used; input changes while in WAIT are ignored.
//  - mem_ce_i=0 while in WAIT (flush) -> abort: go IDLE, no write, mem_data_o unchanged.
//  - Back-to-back: new ce in the cycle after DONE starts a fresh access from IDLE.
//  - mem_data_o holds its last load value until the next load completes; stores leave it unchanged.
//  - Address wraps modulo depth (upper bits ignored) unless DMEM_ERR_EN.
//  - Reset mid-access: access abandoned, no partial write.
// CONFIGURATION
//  DMEM_ERR_EN defined: addr[31:ADDR_W+2] != 0 is out-of-range.
//   An out-of-range store writes nothing. An out-of-range load captures 32'h0.
//   mem_err_o=1 exactly in the DONE cycle; timing is unchanged.
//  DMEM_ERR_EN undefined: no mem_err_o port; addresses wrap.
// STRUCTURE
//  Shared define.v gains: DMEM state encodings (IDLE/WAIT/DONE), `DmemWaitBus [3:0], `DmemDefaultWait.
//  It reuses `RegBus, `ChipEnable, `WriteEnable.
//  Sub-module dmem_lane_ram: one 8-bit x 2**ADDR_W synchronous RAM with a write enable.
//  It is instantiated 4x, one per byte lane.
// TESTING
//  1 WAIT_CYCLES=1: SW addr 0x10 data 0xDEADBEEF sel 1111, then LW addr 0x10
//    -> stallreq high 3 cycles per access; mem_data_o=0xDEADBEEF.
//  2 Word 0x10=0xDEADBEEF: SB sel 0100 data 0x55555555, then LW 0x10 -> 0xDE55BEEF.
//    Then SH sel 0011 data 0x12341234, LW -> 0xDE551234.
//  3 WAIT_CYCLES=0: back-to-back SW 0x20 / LW 0x20 -> each stalls exactly 2 cycles; correct data returned.
//  4 SW issued, ce dropped after 1 WAIT cycle -> FSM in IDLE next cycle; later LW shows old contents.
//  5 rst asserted during WAIT of a store -> outputs zero immediately; word unchanged after reset release.
//  6 ADDR_W=10, LW 0x1000 (with DMEM_ERR_EN) -> mem_err_o=1 in DONE, mem_data_o=0.
//    Without DMEM_ERR_EN -> returns the word at 0x0000.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder (FSM states, wait counter, bus widths).
package dmem_resp_pkg;

    localparam int REG_W             = 32;
    localparam int DMEM_WAIT_W       = 4;
    localparam int DMEM_DEFAULT_WAIT = 1;

    typedef logic [REG_W-1:0]       reg_bus_t;
    typedef logic [DMEM_WAIT_W-1:0] dmem_wait_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } dmem_state_t;

    // Any address bit above the word index makes the access fall outside the RAM.
    function automatic logic addr_out_of_range(input reg_bus_t addr, input int addr_w);
        return (addr >> (addr_w + 2)) != '0;
    endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// One byte lane of the data RAM: synchronous write, combinational read, contents never reset.
module dmem_lane_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder with configurable latency and big-endian byte lanes.
// Define DMEM_ERR_EN to add the out-of-range flag mem_err_o instead of address wrap.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = DMEM_DEFAULT_WAIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq_o
`ifdef DMEM_ERR_EN
    ,
    output logic        mem_err_o
`endif
);

    dmem_state_t state;
    dmem_wait_t  cnt;
    logic        req_we;
    reg_bus_t    req_addr;
    logic [3:0]  req_sel;
    reg_bus_t    req_data;

    logic              access_now;
    logic              req_oor;
    logic [ADDR_W-1:0] word_idx;
    logic [3:0]        lane_we;
    reg_bus_t          rd_word;
    logic              addr_unused;

    assign access_now = (state == ST_WAIT) && mem_ce_i && (cnt == '0);
    assign word_idx   = req_addr[ADDR_W+1:2];
    assign stallreq_o = mem_ce_i && (state != ST_DONE);

`ifdef DMEM_ERR_EN
    assign req_oor     = addr_out_of_range(req_addr, ADDR_W);
    assign addr_unused = ^req_addr[1:0];
`else
    assign req_oor     = 1'b0;
    assign addr_unused = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`endif

    // Lane i holds data bits [8i+7:8i]; lane 3 is byte address 0 (big-endian).
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign lane_we[i] = access_now && req_we && req_sel[i] && !req_oor;

        dmem_lane_ram #(
            .ADDR_W(ADDR_W)
        ) u_lane (
            .clk  (clk),
            .we   (lane_we[i]),
            .addr (word_idx),
            .wdata(req_data[8*i +: 8]),
            .rdata(rd_word[8*i +: 8])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_sel    <= '0;
            req_data   <= '0;
            mem_data_o <= '0;
`ifdef DMEM_ERR_EN
            mem_err_o  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_ce_i) begin
                        req_we   <= mem_we_i;
                        req_addr <= mem_addr_i;
                        req_sel  <= mem_sel_i;
                        req_data <= mem_data_i;
                        cnt      <= dmem_wait_t'(WAIT_CYCLES);
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Requester withdrawing ce is a pipeline flush: abandon the access.
                    if (!mem_ce_i) begin
                        state <= ST_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ST_DONE;
                        if (!req_we) begin
                            mem_data_o <= req_oor ? '0 : rd_word;
                        end
`ifdef DMEM_ERR_EN
                        mem_err_o <= req_oor;
`endif
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
`ifdef DMEM_ERR_EN
                    mem_err_o <= 1'b0;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
